// File: rtl/pipe_if_id_queue.sv
// ----------------------------------------------------------------------------
// pipe_if_id_queue
//
// Receive-side buffer between the fetch (IF) and decode (ID) stages. Fetched
// packets {pc, instruction} are accepted under a valid/ready handshake, held
// in order in a small circular buffer, and presented to the decoder under a
// second valid/ready handshake. A flush (redirect) empties the queue on the
// next edge. Two saturating performance counters record decoder stall cycles
// (head valid, decoder not ready) and bubble cycles (decoder ready, no head).
//
// Parameters:
//   DEPTH  number of packet entries (power of two, >= 2)
//   XLEN   width of the pc and instruction fields
//   CNT_W  width of each performance counter
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous, active-high reset
//   if_valid_i    fetch offers a packet
//   if_pc_i       pc of the offered packet
//   if_inst_i     instruction word of the offered packet
//   id_ready_o    queue can accept a packet this cycle (registered state only)
//   dec_valid_o   head packet valid toward the decoder
//   dec_pc_o      pc of the head packet
//   dec_inst_o    instruction of the head packet
//   dec_ready_i   decoder consumes the head packet this cycle
//   flush_i       discard all held packets
//   count_o       current occupancy
//   stall_cnt_o   cycles with dec_valid_o=1 and dec_ready_i=0 (saturating)
//   bubble_cnt_o  cycles with dec_ready_i=1 and dec_valid_o=0 (saturating)
// ----------------------------------------------------------------------------
module pipe_if_id_queue #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       if_valid_i,
   input  logic [XLEN-1:0]            if_pc_i,
   input  logic [XLEN-1:0]            if_inst_i,
   output logic                       id_ready_o,
   output logic                       dec_valid_o,
   output logic [XLEN-1:0]            dec_pc_o,
   output logic [XLEN-1:0]            dec_inst_o,
   input  logic                       dec_ready_i,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [CNT_W-1:0]           stall_cnt_o,
   output logic [CNT_W-1:0]           bubble_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_EMPTY = '0;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [XLEN-1:0]  pc_mem_q   [DEPTH];
   logic [XLEN-1:0]  pc_mem_d   [DEPTH];
   logic [XLEN-1:0]  inst_mem_q [DEPTH];
   logic [XLEN-1:0]  inst_mem_d [DEPTH];

   logic [PTR_W-1:0] wp_q;
   logic [PTR_W-1:0] wp_d;
   logic [PTR_W-1:0] rp_q;
   logic [PTR_W-1:0] rp_d;
   logic [OCC_W-1:0] cnt_q;
   logic [OCC_W-1:0] cnt_d;

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_d;

   // ------------------------------------------------------------------------
   // Handshake qualification
   // ------------------------------------------------------------------------
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic stall_cycle;
   logic bubble_cycle;

   // Ready/valid come from registered occupancy only, so there is no
   // combinational path from dec_ready_i back to id_ready_o.
   always_comb begin
      full         = (cnt_q == OCC_FULL);
      empty        = (cnt_q == OCC_EMPTY);
      push         = if_valid_i & ~full & ~flush_i;
      pop          = ~empty & dec_ready_i & ~flush_i;
      // Counter conditions look at the pre-flush outputs of this cycle.
      stall_cycle  = ~empty & ~dec_ready_i;
      bubble_cycle = dec_ready_i & empty;
   end

   // ------------------------------------------------------------------------
   // Next-state: pointers, occupancy, payload storage
   // ------------------------------------------------------------------------
   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      cnt_d      = cnt_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;

      if (flush_i) begin
         // Payload is left in place; only the bookkeeping is cleared.
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            pc_mem_d[wp_q]   = if_pc_i;
            inst_mem_d[wp_q] = if_inst_i;
            wp_d             = wp_q + PTR_W'(1);
         end
         if (pop) begin
            rp_d = rp_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Next-state: saturating performance counters (never cleared by flush)
   // ------------------------------------------------------------------------
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;

      if (stall_cycle && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (bubble_cycle && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp_q         <= '0;
         rp_q         <= '0;
         cnt_q        <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         cnt_q        <= cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // Storage is reset so the decoder-facing payload reads zero after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= pc_mem_d[i];
            inst_mem_q[i] <= inst_mem_d[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      id_ready_o   = ~full;
      dec_valid_o  = ~empty;
      dec_pc_o     = pc_mem_q[rp_q];
      dec_inst_o   = inst_mem_q[rp_q];
      count_o      = cnt_q;
      stall_cnt_o  = stall_cnt_q;
      bubble_cnt_o = bubble_cnt_q;
   end

endmodule

// File: tb/tb_pipe_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_pipe_if_id_queue
//
// Self-checking bench for pipe_if_id_queue (DEPTH=2, XLEN=32, CNT_W=4 so the
// counters can be driven into saturation quickly). Inputs change just after
// the falling edge and outputs are sampled 1 time unit later, well away from
// the rising edge. A bench-side occupancy/counter model predicts ready,
// valid, count and the counters; accepted packets go into a scoreboard queue
// and are compared against the decoder outputs whenever the DUT hands one out.
// ----------------------------------------------------------------------------
module tb_pipe_if_id_queue;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic             clk_i;
   logic             rst_i;
   logic             if_valid_i;
   logic [XLEN-1:0]  if_pc_i;
   logic [XLEN-1:0]  if_inst_i;
   logic             id_ready_o;
   logic             dec_valid_o;
   logic [XLEN-1:0]  dec_pc_o;
   logic [XLEN-1:0]  dec_inst_o;
   logic             dec_ready_i;
   logic             flush_i;
   logic [OCC_W-1:0] count_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] bubble_cnt_o;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } pkt_t;

   pkt_t expQ[$];
   int   modelCnt;
   int   modelStall;
   int   modelBubble;
   logic lastAccepted;
   int   testsRun;
   int   testsFailed;

   pipe_if_id_queue #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .if_valid_i   (if_valid_i),
      .if_pc_i      (if_pc_i),
      .if_inst_i    (if_inst_i),
      .id_ready_o   (id_ready_o),
      .dec_valid_o  (dec_valid_o),
      .dec_pc_o     (dec_pc_o),
      .dec_inst_o   (dec_inst_o),
      .dec_ready_i  (dec_ready_i),
      .flush_i      (flush_i),
      .count_o      (count_o),
      .stall_cnt_o  (stall_cnt_o),
      .bubble_cnt_o (bubble_cnt_o)
   );

   // Free-running clock, period 10.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Hard time limit so the bench always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", testsRun, testsFailed);
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every comparison and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      expQ.delete();
      modelCnt    = 0;
      modelStall  = 0;
      modelBubble = 0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_id_ready"},  32'(id_ready_o),   32'd1);
      checkOutput({tag, "_dec_valid"}, 32'(dec_valid_o),  32'd0);
      checkOutput({tag, "_dec_pc"},    dec_pc_o,          32'd0);
      checkOutput({tag, "_dec_inst"},  dec_inst_o,        32'd0);
      checkOutput({tag, "_count"},     32'(count_o),      32'd0);
      checkOutput({tag, "_stall"},     32'(stall_cnt_o),  32'd0);
      checkOutput({tag, "_bubble"},    32'(bubble_cnt_o), 32'd0);
   endtask

   // One clock cycle: drive inputs (called just after a falling edge), check
   // the DUT against the model, advance the model, then run to the next
   // falling edge.
   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                input logic dr, input logic fl);
      logic mValid;
      logic mPush;
      logic mPop;
      pkt_t exp;
      if_valid_i  = v;
      if_pc_i     = pc;
      if_inst_i   = inst;
      dec_ready_i = dr;
      flush_i     = fl;
      #1;
      mValid = (modelCnt != 0);
      mPush  = v && (modelCnt != DEPTH) && !fl;
      mPop   = mValid && dr && !fl;

      checkOutput("id_ready",  32'(id_ready_o),   32'(modelCnt != DEPTH));
      checkOutput("dec_valid", 32'(dec_valid_o),  32'(mValid));
      checkOutput("count",     32'(count_o),      32'(modelCnt));
      checkOutput("stall_cnt", 32'(stall_cnt_o),  32'(modelStall));
      checkOutput("bubble_cnt",32'(bubble_cnt_o), 32'(modelBubble));

      if (dec_valid_o && dec_ready_i && !flush_i) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_pop", 32'd1, 32'd0);
         end else begin
            exp = expQ.pop_front();
            checkOutput("dec_pc",   dec_pc_o,   exp.pc);
            checkOutput("dec_inst", dec_inst_o, exp.inst);
         end
      end

      if (mValid && !dr && modelStall != CNT_SAT) modelStall++;
      if (dr && !mValid && modelBubble != CNT_SAT) modelBubble++;
      if (fl) begin
         expQ.delete();
         modelCnt = 0;
      end else begin
         if (mPush) expQ.push_back('{pc: pc, inst: inst});
         modelCnt = modelCnt + int'(mPush) - int'(mPop);
      end
      lastAccepted = mPush;

      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Offer a packet and hold it until accepted, bounded by a cycle budget.
   task automatic sendHeld(input logic [31:0] pc, input logic [31:0] inst, input logic dr);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         applyStimulus(1'b1, pc, inst, dr, 1'b0);
         done = lastAccepted;
      end
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      lastAccepted = 1'b0;
      resetModel();
      rst_i        = 1'b1;
      if_valid_i   = 1'b0;
      if_pc_i      = '0;
      if_inst_i    = '0;
      dec_ready_i  = 1'b0;
      flush_i      = 1'b0;

      #1;
      checkResetValues("reset");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Idle with decoder ready: five bubble cycles, no stalls.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      checkOutput("idle_bubble", 32'(bubble_cnt_o), 32'd5);
      checkOutput("idle_stall",  32'(stall_cnt_o),  32'd0);
      checkOutput("idle_ready",  32'(id_ready_o),   32'd1);
      checkOutput("idle_valid",  32'(dec_valid_o),  32'd0);

      // Single packet: visible the cycle after acceptance, then popped.
      applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b1, 1'b0);
      #1;
      checkOutput("single_valid", 32'(dec_valid_o), 32'd1);
      checkOutput("single_pc",    dec_pc_o,         32'h8000_0000);
      checkOutput("single_inst",  dec_inst_o,       32'h0000_0013);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      checkOutput("single_count", 32'(count_o), 32'd0);

      // Decoder stalled: two packets accepted, third held off until space.
      applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
      #1;
      checkOutput("full_ready", 32'(id_ready_o), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h8000_0008, 32'h0020_0113, 1'b0, 1'b0);
      #1;
      checkOutput("stall_count4", 32'(stall_cnt_o), 32'd4);
      sendHeld(32'h8000_0008, 32'h0020_0113, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("stall_drain_empty", 32'(expQ.size()), 32'd0);

      // Streaming: one packet per cycle, pointers wrap repeatedly.
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b1, 32'h8000_0000 + 32'(4 * k), 32'h0000_0013 | (32'(k) << 7), 1'b1, 1'b0);
         if (k > 0) checkOutput("stream_count", 32'(count_o), 32'd1);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("stream_drain_empty", 32'(expQ.size()), 32'd0);

      // Flush while full with a packet offered: it must never reach decode.
      applyStimulus(1'b1, 32'h8000_0100, 32'h0000_0113, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h8000_0104, 32'h0000_0213, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
      #1;
      checkOutput("flush_count", 32'(count_o),     32'd0);
      checkOutput("flush_valid", 32'(dec_valid_o), 32'd0);
      checkOutput("flush_ready", 32'(id_ready_o),  32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Stall counter saturates at all-ones.
      applyStimulus(1'b1, 32'h8000_0200, 32'h0000_0313, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput("stall_saturated", 32'(stall_cnt_o), 32'(CNT_SAT));

      // Asynchronous reset mid-stream: outputs return before the next edge.
      if_valid_i  = 1'b1;
      if_pc_i     = 32'h8000_0300;
      if_inst_i   = 32'h0000_0413;
      dec_ready_i = 1'b0;
      #1;
      rst_i = 1'b1;
      #1;
      checkResetValues("async_reset");
      resetModel();
      @(negedge clk_i);
      rst_i = 1'b0;

      // Function after reset.
      applyStimulus(1'b1, 32'h8000_0400, 32'h0000_0513, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("final_empty", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
